serial_subtractor_16bit: RTL and testbench

//  Multi-cycle digit-serial subtractor; inverse operation of the team's clocked adder.

---
 rtl/serial_arith_pkg.sv | 24 ++
 rtl/fsub_digit.sv | 25 ++
 rtl/serial_subtractor_16bit.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor_16bit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM encoding,
// default operand geometry and a constant-safe clog2 helper.
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DIGIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } serial_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fsub_digit.sv
// Combinational DIGIT-bit borrow-ripple subtractor: o_diff = i_x - i_y - i_bin,
// built from a chain of full-subtractor cells.
module fsub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_bin,
  output logic [DIGIT-1:0] o_diff,
  output logic             o_bout
);

  always_comb begin
    logic w_b;
    w_b    = i_bin;
    o_diff = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      o_diff[i] = i_x[i] ^ i_y[i] ^ w_b;
      // Borrow when y exceeds x, or they tie and a borrow is already pending.
      w_b       = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_b);
    end
    o_bout = w_b;
  end

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial subtractor p = a - d - borrowin, WIDTH/DIGIT clocks per result.
// Optional signed-overflow output ovf enabled by defining SUB_OVERFLOW_FLAG_EN.
module serial_subtractor_16bit
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             borrowin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p,
  output logic             borrowout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (clog2(NDIG) > 0) ? clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_subtractor_16bit: DIGIT must divide WIDTH exactly");
  end

  serial_state_e    r_state;
  serial_state_e    w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_res;
  logic             r_bor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_p;
  logic             r_bout;

  logic [DIGIT-1:0] w_diff;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  fsub_digit #(
    .DIGIT (DIGIT)
  ) u_fsub_digit (
    .i_x    (r_a[DIGIT-1:0]),
    .i_y    (r_d[DIGIT-1:0]),
    .i_bin  (r_bor),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  // New digits enter at the MSB end so the last digit lands the result in place.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_diff) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_d    <= '0;
      r_res  <= '0;
      r_bor  <= 1'b0;
      r_cnt  <= '0;
      r_p    <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_d   <= d;
      r_bor <= borrowin;
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> DIGIT;
      r_d   <= r_d >> DIGIT;
      r_res <= w_res_next;
      r_bor <= w_bout;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_p    <= w_res_next;
        r_bout <= w_bout;
      end
    end
  end

`ifdef SUB_OVERFLOW_FLAG_EN
  // Operand sign bits are shifted out during RUN, so keep them from the accept cycle.
  logic r_a_msb;
  logic r_d_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_d_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_d_msb <= d[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb != r_d_msb) && (w_res_next[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign p         = r_p;
  assign borrowout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Directed self-checking bench for serial_subtractor_16bit (DIGIT=1 and DIGIT=4 instances).
module tb_serial_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, bin, busy, done, bout;
  logic [15:0] a, d, p;
  logic        start4, bin4, busy4, done4, bout4;
  logic [15:0] a4, d4, p4;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic        ovf, ovf4;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor_16bit #(
    .WIDTH (16),
    .DIGIT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .borrowin  (bin),
    .a         (a),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .p         (p),
    .borrowout (bout)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  serial_subtractor_16bit #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .borrowin  (bin4),
    .a         (a4),
    .d         (d4),
    .busy      (busy4),
    .done      (done4),
    .p         (p4),
    .borrowout (bout4)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf4)
`endif
  );

  task automatic go(input logic [15:0] ta, input logic [15:0] td, input logic tbin);
    a = ta; d = td; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic go4(input logic [15:0] ta, input logic [15:0] td, input logic tbin);
    a4 = ta; d4 = td; bin4 = tbin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // Returns the number of edges until done is seen (40 means it never came).
  task automatic wait_done(input bit use4, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if ((use4 ? done4 : done) === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (p !== 16'd0) begin n_err++; $display("FAIL reset_p: got %0d want 0", p); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b want 0", bout); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int cyc;
    go(16'd510, 16'd60, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(1'b0, cyc);
    n_vec++; if (cyc != 16) begin n_err++; $display("FAIL basic_latency: got %0d want 16", cyc); end
    n_vec++; if (p !== 16'd450) begin n_err++; $display("FAIL basic_p: got %0d want 450", p); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL basic_bout: got %b want 0", bout); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_vec++; if (p !== 16'd450) begin n_err++; $display("FAIL basic_p_hold: got %0d want 450", p); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    go(16'd30, 16'd600, 1'b0);
    wait_done(1'b0, cyc);
    n_vec++; if (cyc != 16) begin n_err++; $display("FAIL b2b_lat1: got %0d want 16", cyc); end
    n_vec++; if (p !== 16'd64966) begin n_err++; $display("FAIL b2b_p1: got %0d want 64966", p); end
    n_vec++; if (bout !== 1'b1) begin n_err++; $display("FAIL b2b_bout1: got %b want 1", bout); end
    go(16'd520, 16'd602, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(1'b0, cyc);
    n_vec++; if (cyc != 16) begin n_err++; $display("FAIL b2b_lat2: got %0d want 16", cyc); end
    n_vec++; if (p !== 16'd65454) begin n_err++; $display("FAIL b2b_p2: got %0d want 65454", p); end
    n_vec++; if (bout !== 1'b1) begin n_err++; $display("FAIL b2b_bout2: got %b want 1", bout); end
  endtask

  task automatic test_start_ignored;
    int ndone;
    logic [15:0] p_seen;
    logic        b_seen;
    ndone = 0; p_seen = '0; b_seen = 1'b0;
    go(16'd1500, 16'd1160, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    a = 16'd9; d = 16'd8; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        p_seen = p;
        b_seen = bout;
      end
    end
    n_vec++; if (ndone != 1) begin n_err++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
    n_vec++; if (p_seen !== 16'd339) begin n_err++; $display("FAIL ign_p: got %0d want 339", p_seen); end
    n_vec++; if (b_seen !== 1'b0) begin n_err++; $display("FAIL ign_bout: got %b want 0", b_seen); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle: got %b want 0", busy); end
  endtask

  task automatic test_operands_while_busy;
    int cyc;
    go(16'h1234, 16'h1234, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a = 16'hFFFF; d = 16'h0000; bin = 1'b0;
    wait_done(1'b0, cyc);
    n_vec++; if (p !== 16'hFFFF) begin n_err++; $display("FAIL eq_p: got %h want ffff", p); end
    n_vec++; if (bout !== 1'b1) begin n_err++; $display("FAIL eq_bout: got %b want 1", bout); end
  endtask

  task automatic test_boundary;
    int cyc;
    go(16'h0000, 16'h0000, 1'b1);
    wait_done(1'b0, cyc);
    n_vec++; if (p !== 16'hFFFF) begin n_err++; $display("FAIL zero_p: got %h want ffff", p); end
    n_vec++; if (bout !== 1'b1) begin n_err++; $display("FAIL zero_bout: got %b want 1", bout); end
    go(16'hFFFF, 16'h0000, 1'b0);
    wait_done(1'b0, cyc);
    n_vec++; if (p !== 16'hFFFF) begin n_err++; $display("FAIL max_p: got %h want ffff", p); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL max_bout: got %b want 0", bout); end
  endtask

`ifdef SUB_OVERFLOW_FLAG_EN
  task automatic test_ovf;
    int cyc;
    go(16'h8000, 16'h0001, 1'b0);
    wait_done(1'b0, cyc);
    n_vec++; if (p !== 16'h7FFF) begin n_err++; $display("FAIL ovf_p: got %h want 7fff", p); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
    go(16'd5, 16'd3, 1'b0);
    wait_done(1'b0, cyc);
    n_vec++; if (p !== 16'd2) begin n_err++; $display("FAIL ovf_p2: got %0d want 2", p); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    go4(16'h8000, 16'h0001, 1'b0);
    wait_done(1'b1, cyc);
    n_vec++; if (ovf4 !== 1'b1) begin n_err++; $display("FAIL ovf4_set: got %b want 1", ovf4); end
  endtask
`endif

  task automatic test_digit4;
    int cyc;
    go4(16'd510, 16'd60, 1'b0);
    wait_done(1'b1, cyc);
    n_vec++; if (cyc != 4) begin n_err++; $display("FAIL d4_lat: got %0d want 4", cyc); end
    n_vec++; if (p4 !== 16'd450) begin n_err++; $display("FAIL d4_p: got %0d want 450", p4); end
    n_vec++; if (bout4 !== 1'b0) begin n_err++; $display("FAIL d4_bout: got %b want 0", bout4); end
    go4(16'd30, 16'd600, 1'b0);
    wait_done(1'b1, cyc);
    n_vec++; if (p4 !== 16'd64966) begin n_err++; $display("FAIL d4_p1: got %0d want 64966", p4); end
    n_vec++; if (bout4 !== 1'b1) begin n_err++; $display("FAIL d4_bout1: got %b want 1", bout4); end
    go4(16'd520, 16'd602, 1'b0);
    wait_done(1'b1, cyc);
    n_vec++; if (cyc != 4) begin n_err++; $display("FAIL d4_lat2: got %0d want 4", cyc); end
    n_vec++; if (p4 !== 16'd65454) begin n_err++; $display("FAIL d4_p2: got %0d want 65454", p4); end
    n_vec++; if (bout4 !== 1'b1) begin n_err++; $display("FAIL d4_bout2: got %b want 1", bout4); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    ndone = 0;
    go(16'd510, 16'd60, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", done); end
    n_vec++; if (p !== 16'd0) begin n_err++; $display("FAIL rmid_p: got %0d want 0", p); end
    n_vec++; if (bout !== 1'b0) begin n_err++; $display("FAIL rmid_bout: got %b want 0", bout); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    n_vec++; if (ndone != 0) begin n_err++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; bin = 1'b0; a = '0; d = '0;
    start4 = 1'b0; bin4 = 1'b0; a4 = '0; d4 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_operands_while_busy();
    test_boundary();
`ifdef SUB_OVERFLOW_FLAG_EN
    test_ovf();
`endif
    test_digit4();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
